// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM slave state type.
// Also holds the byte-lane mask helper used for partial-word writes.
package ahb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } slave_state_e;

  // Little-endian lane mask; only meaningful for transfers that passed the error check.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SIZE_BYTE: m = 4'b0001 << lo;
      SIZE_HALF: m = 4'b0011 << {lo[1], 1'b0};
      SIZE_WORD: m = 4'b1111;
      default:   m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite bus signals between a master and the SRAM slave.
// Handshake: an address phase is taken at a rising edge with HSEL=1 and HREADY=1; a data phase ends at the first edge with HREADY=1.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HWDATA,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// Word-organised backing store: byte-enabled synchronous write, combinational read.
// Contents are deliberately not reset.
module ahb_slave_mem #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: address decode, error check, wait-state FSM and data-phase muxing.
// The state register is exported on state_dbg for observation.
import ahb_pkg::*;

module ahb_sram_slave #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 10
) (
  input  logic               clk,
  input  logic               n_rst,
  ahb_sram_slave_if.slave    bus,
  output slave_state_e       state_dbg
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  slave_state_e         state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS+1:0] addr_q;
  logic                 write_q;
  logic [1:0]           size_q;

  logic        hready;
  logic        accept;
  logic        req_err;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  assign hready = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept = bus.HSEL && hready;

  assign req_err = (bus.HSIZE == 2'b11)
                || ((bus.HSIZE == SIZE_HALF) && bus.HADDR[0])
                || ((bus.HSIZE == SIZE_WORD) && (bus.HADDR[1:0] != 2'b00))
                || (bus.HADDR[31:ADDR_BITS+2] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end else if (req_err) begin
          state_d = ST_ERR1;
        end else if (WAIT_CYCLES > 0) begin
          state_d = ST_WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.HADDR[ADDR_BITS+1:0];
        write_q <= bus.HWRITE;
        size_q  <= bus.HSIZE;
      end
    end
  end

  // Write commits on the edge that ends DONE, ahead of any pipelined read's data phase.
  assign mem_we = (state_q == ST_DONE) && write_q;
  assign mem_be = lane_mask(size_q, addr_q[1:0]);

  ahb_slave_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (addr_q[ADDR_BITS+1:2]),
    .wdata (bus.HWDATA),
    .rdata (mem_rdata)
  );

  assign bus.HREADY = hready;
  assign bus.HRESP  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign bus.HRDATA = ((state_q == ST_DONE) && !write_q) ? mem_rdata : 32'h0;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a 2-wait-state instance and a zero-wait instance share one driver;
// directed cases plus random traffic checked against an array model of memory.
import ahb_pkg::*;

module tb_ahb_sram_slave;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // stimulus shared by both instances; use_fast selects which one is selected and observed
  logic        use_fast = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic        hwrite = 1'b0;
  logic [1:0]  hsize = 2'b00;
  logic [31:0] hwdata = 32'h0;
  logic        hready, hresp;
  logic [31:0] hrdata;
  slave_state_e state_s, state_f;

  ahb_sram_slave_if bus_s ();
  ahb_sram_slave_if bus_f ();

  assign bus_s.HSEL = hsel & ~use_fast;
  assign bus_f.HSEL = hsel & use_fast;
  assign bus_s.HADDR = haddr;   assign bus_f.HADDR = haddr;
  assign bus_s.HWRITE = hwrite; assign bus_f.HWRITE = hwrite;
  assign bus_s.HSIZE = hsize;   assign bus_f.HSIZE = hsize;
  assign bus_s.HWDATA = hwdata; assign bus_f.HWDATA = hwdata;

  assign hready = use_fast ? bus_f.HREADY : bus_s.HREADY;
  assign hresp  = use_fast ? bus_f.HRESP  : bus_s.HRESP;
  assign hrdata = use_fast ? bus_f.HRDATA : bus_s.HRDATA;

  ahb_sram_slave #(.WAIT_CYCLES(2), .ADDR_BITS(10)) dut_s (
    .clk(clk), .n_rst(n_rst), .bus(bus_s), .state_dbg(state_s)
  );
  ahb_sram_slave #(.WAIT_CYCLES(0), .ADDR_BITS(10)) dut_f (
    .clk(clk), .n_rst(n_rst), .bus(bus_f), .state_dbg(state_f)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] model_mem [0:1][0:1023];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit is_err(input logic [31:0] addr, input logic [1:0] size);
    return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
           (size == 2'd2 && (addr % 4) != 0) || ((addr >> 12) != 0);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return model_mem[use_fast ? 1 : 0][(addr >> 2) % 1024];
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    int d;
    int w;
    int first;
    int nbytes;
    logic [31:0] v;
    d = use_fast ? 1 : 0;
    w = (addr >> 2) % 1024;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    first = (size == 2'd2) ? 0 : (addr % 4);
    v = model_mem[d][w];
    for (int b = first; b < first + nbytes; b++) v[8*b +: 8] = wdata[8*b +: 8];
    model_mem[d][w] = v;
  endtask

  // ---------------- driver ----------------
  // One non-pipelined transfer on the selected instance; checks wait length, response and read data.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wdata, input string tag);
    bit err;
    int lows;
    bit bad_wait;
    logic [31:0] exp_rd;
    err = is_err(addr, size);
    hsel = 1'b1; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; haddr = $urandom; hwrite = 1'($urandom); hsize = 2'($urandom); hwdata = wdata;
    lows = 0;
    bad_wait = 1'b0;
    @(negedge clk);
    while (!hready && lows < 40) begin
      lows++;
      if (err ? (hresp !== 1'b1) : (hresp !== 1'b0 || hrdata !== 32'h0)) bad_wait = 1'b1;
      @(negedge clk);
    end
    check({tag, "_lowcyc"}, 32'(lows), err ? 32'd1 : (use_fast ? 32'd0 : 32'd2));
    check({tag, "_waitout"}, 32'(bad_wait), 32'd0);
    check({tag, "_resp"}, 32'(hresp), 32'(err));
    exp_rd = (!wr && !err) ? model_read(addr) : 32'h0;
    check({tag, "_rdata"}, hrdata, exp_rd);
    @(posedge clk); #1;
    if (wr && !err) model_write(addr, size, wdata);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hready", 32'(bus_s.HREADY), 32'd1);
    check("rst_hresp", 32'(bus_s.HRESP), 32'd0);
    check("rst_hrdata", bus_s.HRDATA, 32'h0);
    check("rst_state", 32'(state_s), 32'(ST_IDLE));
    check("rst_state_f", 32'(state_f), 32'(ST_IDLE));
    n_rst = 1'b1;
    @(posedge clk); #1;

    // ---------------- slow instance directed ----------------
    use_fast = 1'b0;
    xfer(1'b1, 32'h0000_04D8, SIZE_WORD, 32'h0039_3421, "w4d8");
    xfer(1'b0, 32'h0000_04D8, SIZE_WORD, 32'h0, "r4d8");
    check("r4d8_const", model_read(32'h4D8), 32'h0039_3421);

    xfer(1'b1, 32'h0, SIZE_WORD, 32'hFFFF_FFFF, "w0");
    xfer(1'b1, 32'h1, SIZE_BYTE, 32'hABAB_ABAB, "wb1");
    xfer(1'b0, 32'h0, SIZE_WORD, 32'h0, "r0_byte");
    check("byte_lane_const", model_read(32'h0), 32'hFFFF_ABFF);

    xfer(1'b1, 32'h3, SIZE_HALF, 32'h5555_5555, "err_half");
    xfer(1'b1, 32'h1000_0000, SIZE_WORD, 32'h6666_6666, "err_range");
    xfer(1'b0, 32'h0, SIZE_WORD, 32'h0, "r0_after_err");

    // reset during WAIT aborts an uncommitted write
    hsel = 1'b1; haddr = 32'h4D8; hwrite = 1'b1; hsize = SIZE_WORD;
    @(posedge clk); #1;
    hsel = 1'b0; hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("midrst_in_wait", 32'(hready), 32'd0);
    #1 n_rst = 1'b0;
    #1;
    check("midrst_hready", 32'(hready), 32'd1);
    check("midrst_hresp", 32'(hresp), 32'd0);
    check("midrst_hrdata", hrdata, 32'h0);
    check("midrst_state", 32'(state_s), 32'(ST_IDLE));
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h4D8, SIZE_WORD, 32'h0, "r4d8_after_rst");

    // idle select with a busy-looking bus
    for (int i = 0; i < 3; i++) begin
      hsel = 1'b0; haddr = $urandom_range(0, 1023) * 4; hwrite = 1'($urandom); hsize = SIZE_WORD;
      hwdata = $urandom;
      @(negedge clk);
      check("idle_hready", 32'(hready), 32'd1);
      check("idle_hresp", 32'(hresp), 32'd0);
      check("idle_hrdata", hrdata, 32'h0);
      @(posedge clk); #1;
    end
    xfer(1'b0, 32'h4D8, SIZE_WORD, 32'h0, "r4d8_after_idle");

    // ---------------- fast instance: back-to-back write then read ----------------
    use_fast = 1'b1;
    hsel = 1'b1; haddr = 32'h8; hwrite = 1'b1; hsize = SIZE_WORD;
    @(posedge clk); #1;
    haddr = 32'h8; hwrite = 1'b0; hwdata = 32'h1234_5678;
    @(negedge clk);
    check("b2b_wr_hready", 32'(hready), 32'd1);
    @(posedge clk); #1;
    hsel = 1'b0;
    model_write(32'h8, SIZE_WORD, 32'h1234_5678);
    @(negedge clk);
    check("b2b_rd_hready", 32'(hready), 32'd1);
    check("b2b_rd_hrdata", hrdata, 32'h1234_5678);
    @(posedge clk); #1;

    // ---------------- random traffic on both instances ----------------
    for (int d = 0; d < 2; d++) begin
      use_fast = 1'(d);
      for (int w = 0; w < 16; w++) xfer(1'b1, 32'(w * 4), SIZE_WORD, $urandom, "init");
      for (int i = 0; i < 60; i++) begin
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
        sz = 2'($urandom_range(0, 3));
        xfer(1'($urandom_range(0, 1)), a, sz, $urandom, d ? "rnd_f" : "rnd_s");
      end
      for (int w = 0; w < 16; w++) xfer(1'b0, 32'(w * 4), SIZE_WORD, 32'h0, "final_rd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation timeout");
  end

endmodule
